// File: rtl/spi_sram_pkg.sv
// spi_sram_pkg
//   Shared definitions for the 23LC512-compatible SPI SRAM slave:
//   command opcodes, mode-register encodings (mode[7:6]) and the
//   command FSM state type.
package spi_sram_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_RDMR  = 8'h05;
    localparam logic [7:0] OP_WRMR  = 8'h01;

    // Encodings of mode[7:6]; 2'b11 behaves as sequential.
    localparam logic [1:0] MODE_BYTE = 2'b00;
    localparam logic [1:0] MODE_PAGE = 2'b10;
    localparam logic [1:0] MODE_SEQ  = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RD,
        ST_WR,
        ST_RDMR,
        ST_WRMR,
        ST_IGNORE
    } state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Two-flop synchronizer for one asynchronous input, followed by an
//   edge detector that produces single-cycle rise/fall pulses.
// Ports:
//   clock   in   system clock
//   resetb  in   asynchronous active-low reset
//   async_i in   asynchronous input (sck)
//   sync_o  out  synchronized level
//   rise_o  out  one-cycle pulse on a synchronized 0->1 transition
//   fall_o  out  one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge (
    input  logic clock,
    input  logic resetb,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_sram_23lc512.sv
// spi_sram_23lc512
//   SPI mode-0 serial SRAM slave, command compatible with the 23LC512.
//   All SPI pins are oversampled by the system clock; the memory array,
//   mode register and command FSM are internal.
// Ports:
//   clock   in   system clock, rising edge
//   resetb  in   asynchronous active-low reset
//   sck     in   SPI clock (asynchronous to clock)
//   cs_n    in   chip select, active low
//   si      in   serial data in (MOSI)
//   hold_n  in   hold, active low
//   so      out  serial data out (MISO), registered
//   so_oe   out  output enable for so
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | deselected, waiting for cs_n low
// ST_CMD     | shifting in the 8-bit opcode
// ST_ADDR    | shifting in the 16-bit address
// ST_RD      | shifting out array bytes, address advancing per mode
// ST_WR      | shifting in bytes, committing each on its 8th rise
// ST_RDMR    | shifting out the mode register repeatedly
// ST_WRMR    | shifting in the new mode byte
// ST_IGNORE  | unknown opcode or finished WRMR; wait for cs_n high
module spi_sram_23lc512
    import spi_sram_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          PAGE_W   = 5,
    parameter logic [7:0]  MODE_RST = 8'h40
) (
    input  logic clock,
    input  logic resetb,
    input  logic sck,
    input  logic cs_n,
    input  logic si,
    input  logic hold_n,
    output logic so,
    output logic so_oe
);

    logic sck_s;
    logic sck_rise;
    logic sck_fall;

    spi_sync_edge u_sck_sync (
        .clock  (clock),
        .resetb (resetb),
        .async_i(sck),
        .sync_o (sck_s),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    // Plain 2-flop synchronizer for the level inputs {cs_n, hold_n, si}.
    // cs_n and hold_n reset to their inactive (high) level.
    logic [2:0] lvl_meta_q;
    logic [2:0] lvl_sync_q;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            lvl_meta_q <= 3'b110;
            lvl_sync_q <= 3'b110;
        end else begin
            lvl_meta_q <= {cs_n, hold_n, si};
            lvl_sync_q <= lvl_meta_q;
        end
    end

    logic cs_s;
    logic hold_s;
    logic si_s;
    assign cs_s   = lvl_sync_q[2];
    assign hold_s = lvl_sync_q[1];
    assign si_s   = lvl_sync_q[0];

    state_e              state_q;
    logic [3:0]          bit_cnt_q;
    logic [14:0]         shift_q;
    logic [7:0]          tx_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [1:0]          mode_q;
    logic                is_read_q;
    logic                drv_q;
    logic                wr_done_q;
    logic                so_q;
    logic                so_oe_q;
    logic [7:0]          mem_q [2**ADDR_W];

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        m);
        logic [ADDR_W-1:0] inc;
        inc = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (m)
            MODE_BYTE: return a;
            MODE_PAGE: return {a[ADDR_W-1:PAGE_W], inc[PAGE_W-1:0]};
            default:   return inc;
        endcase
    endfunction

    // Hold and deselect both mask sck edges, which freezes every register.
    logic              active;
    logic              rise;
    logic              fall;
    logic [15:0]       rx_word;
    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_in;
    logic [ADDR_W-1:0] addr_nxt;
    logic              mem_wr_en;

    assign active   = ~cs_s & hold_s;
    assign rise     = sck_rise & active;
    assign fall     = sck_fall & active;
    assign rx_word  = {shift_q, si_s};
    assign rx_byte  = rx_word[7:0];
    assign addr_in  = rx_word[ADDR_W-1:0];
    assign addr_nxt = next_addr(addr_q, mode_q);

    // Byte mode keeps the address fixed, so only the first byte lands.
    assign mem_wr_en = rise && (state_q == ST_WR) && (bit_cnt_q == 4'd7)
                       && !((mode_q == MODE_BYTE) && wr_done_q);

    always_ff @(posedge clock) begin
        if (mem_wr_en) begin
            mem_q[addr_q] <= rx_byte;
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            mode_q    <= MODE_RST[7:6];
            is_read_q <= 1'b0;
            drv_q     <= 1'b0;
            wr_done_q <= 1'b0;
            so_q      <= 1'b0;
            so_oe_q   <= 1'b0;
        end else if (cs_s) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 4'd0;
            drv_q     <= 1'b0;
            wr_done_q <= 1'b0;
            so_oe_q   <= 1'b0;
        end else begin
            so_oe_q <= drv_q && hold_s && ((state_q == ST_RD) || (state_q == ST_RDMR));
            case (state_q)
                ST_IDLE: begin
                    state_q   <= ST_CMD;
                    bit_cnt_q <= 4'd0;
                end
                ST_CMD: begin
                    if (rise) begin
                        shift_q <= rx_word[14:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            case (rx_byte)
                                OP_READ: begin
                                    state_q   <= ST_ADDR;
                                    is_read_q <= 1'b1;
                                end
                                OP_WRITE: begin
                                    state_q   <= ST_ADDR;
                                    is_read_q <= 1'b0;
                                end
                                OP_RDMR: begin
                                    state_q <= ST_RDMR;
                                    tx_q    <= {mode_q, 6'b0};
                                end
                                OP_WRMR: state_q <= ST_WRMR;
                                default: state_q <= ST_IGNORE;
                            endcase
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        shift_q <= rx_word[14:0];
                        if (bit_cnt_q == 4'd15) begin
                            bit_cnt_q <= 4'd0;
                            addr_q    <= addr_in;
                            if (is_read_q) begin
                                state_q <= ST_RD;
                                tx_q    <= mem_q[addr_in];
                            end else begin
                                state_q <= ST_WR;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD, ST_RDMR: begin
                    // The bit driven here is sampled by the master on the next rise;
                    // the following byte is fetched while its LSB is on the wire.
                    if (fall) begin
                        so_q    <= tx_q[7];
                        so_oe_q <= 1'b1;
                        drv_q   <= 1'b1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            if (state_q == ST_RD) begin
                                addr_q <= addr_nxt;
                                tx_q   <= mem_q[addr_nxt];
                            end else begin
                                tx_q <= {mode_q, 6'b0};
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            tx_q      <= {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_WR: begin
                    if (rise) begin
                        shift_q <= rx_word[14:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            if (mem_wr_en) begin
                                wr_done_q <= 1'b1;
                                addr_q    <= addr_nxt;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_WRMR: begin
                    if (rise) begin
                        shift_q <= rx_word[14:0];
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= 4'd0;
                            mode_q    <= rx_byte[7:6];
                            state_q   <= ST_IGNORE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                ST_IGNORE: begin
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign so    = so_q;
    assign so_oe = so_oe_q;

endmodule

// File: tb/tb_spi_sram_23lc512.sv
module tb_spi_sram_23lc512;

    logic clock  = 1'b0;
    logic resetb = 1'b0;
    logic sck    = 1'b0;
    logic cs_n   = 1'b1;
    logic si     = 1'b0;
    logic hold_n = 1'b1;
    logic so;
    logic so_oe;

    always #5 clock = ~clock;

    spi_sram_23lc512 dut (
        .clock (clock),
        .resetb(resetb),
        .sck   (sck),
        .cs_n  (cs_n),
        .si    (si),
        .hold_n(hold_n),
        .so    (so),
        .so_oe (so_oe)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: assemble bytes the master would sample on sck rise while the
    // slave drives, and compare each against the scoreboard.
    logic [7:0] mon_sh  = 8'h00;
    int         mon_cnt = 0;

    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            mon_cnt = 0;
        end else if (so_oe === 1'b1) begin
            mon_sh = {mon_sh[6:0], so};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected read byte: got %0h expected none", mon_sh);
                end else begin
                    check("read byte", {24'h0, mon_sh}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_bit(input logic b);
        si = b;
        clks(6);
        sck = 1'b1;
        clks(6);
        sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) spi_bit(v[i]);
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        clks(6);
    endtask

    task automatic cs_end();
        clks(6);
        cs_n = 1'b1;
        clks(3);
        check("so_oe 3 clocks after cs_n high", {31'b0, so_oe}, 32'd0);
        clks(5);
    endtask

    task automatic hdr(input logic [7:0] op, input logic [15:0] addr);
        spi_byte(op);
        spi_byte(addr[15:8]);
        spi_byte(addr[7:0]);
    endtask

    task automatic hold_pulse();
        clks(6);
        hold_n = 1'b0;
        clks(6);
        check("so_oe during hold", {31'b0, so_oe}, 32'd0);
        repeat (2) begin
            sck = 1'b1;
            clks(6);
            sck = 1'b0;
            clks(6);
        end
        hold_n = 1'b1;
        clks(6);
    endtask

    // data holds up to 4 bytes, first byte in [31:24]
    task automatic write_mem(input logic [15:0] addr, input logic [31:0] data, input int n);
        cs_start();
        hdr(8'h02, addr);
        for (int k = 0; k < n; k++) spi_byte(data[31-8*k -: 8]);
        cs_end();
    endtask

    task automatic read_mem(input logic [15:0] addr, input logic [31:0] data, input int n,
                            input int hold_bit);
        cs_start();
        hdr(8'h03, addr);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(data[31-8*k -: 8]);
            for (int i = 0; i < 8; i++) begin
                if (k * 8 + i == hold_bit) hold_pulse();
                spi_bit(1'b0);
            end
        end
        cs_end();
    endtask

    task automatic wrmr(input logic [7:0] v);
        cs_start();
        spi_byte(8'h01);
        spi_byte(v);
        cs_end();
    endtask

    task automatic rdmr(input int n, input logic [7:0] v);
        cs_start();
        spi_byte(8'h05);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back(v);
            spi_byte(8'h00);
        end
        cs_end();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic bad;
        clks(4);
        check("so_oe in reset", {31'b0, so_oe}, 32'd0);
        check("so in reset", {31'b0, so}, 32'd0);
        resetb = 1'b1;
        clks(4);

        // Mode register reset value, read twice
        rdmr(2, 8'h40);

        // Sequential write/read
        write_mem(16'h0010, 32'hA55AC300, 3);
        read_mem(16'h0010, 32'hA55AC300, 3, -1);

        // Known background values
        write_mem(16'h0020, 32'hEE000000, 1);
        write_mem(16'h0100, 32'h3C000000, 1);

        // Page mode: write wraps 0x1F -> 0x00
        wrmr(8'h80);
        rdmr(1, 8'h80);
        write_mem(16'h001E, 32'h11223344, 4);
        read_mem(16'h0000, 32'h33440000, 2, -1);
        read_mem(16'h001E, 32'h11220000, 2, -1);
        read_mem(16'h0020, 32'hEE000000, 1, -1);

        // Sequential mode wraps at top of array
        wrmr(8'h40);
        write_mem(16'hFFFF, 32'h77880000, 2);
        read_mem(16'hFFFF, 32'h77000000, 1, -1);
        read_mem(16'h0000, 32'h88000000, 1, -1);

        // Aborted write: 5 data bits then deselect
        cs_start();
        hdr(8'h02, 16'h0100);
        repeat (5) spi_bit(1'b1);
        cs_end();
        read_mem(16'h0100, 32'h3C000000, 1, -1);

        // Byte mode: second write byte dropped, reads repeat
        wrmr(8'h00);
        write_mem(16'h0200, 32'hD1D20000, 2);
        read_mem(16'h0200, 32'hD1D10000, 2, -1);

        // Reset in the middle of an RDMR transfer
        wrmr(8'h80);
        cs_start();
        spi_byte(8'h05);
        exp_q.push_back(8'h80);
        spi_byte(8'h00);
        clks(2);
        resetb = 1'b0;
        #1;
        check("so_oe after mid-transfer reset", {31'b0, so_oe}, 32'd0);
        clks(4);
        resetb = 1'b1;
        clks(2);
        cs_end();
        rdmr(1, 8'h40);

        // Unknown opcode keeps the output disabled
        cs_start();
        spi_byte(8'hAB);
        bad = 1'b0;
        fork
            spi_byte(8'hFF);
            begin
                repeat (32) begin
                    @(negedge clock);
                    if (so_oe !== 1'b0) bad = 1'b1;
                end
            end
        join
        check("so_oe after unknown opcode", {31'b0, bad}, 32'd0);
        cs_end();

        // Normal read afterwards, with a hold pulse inside the second byte
        read_mem(16'h0010, 32'hA55AC300, 3, 11);

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
